// File: rtl/iter_alu_reg.sv
// iter_alu_reg: accumulator-style ALU with a registered 2*W-bit result.
// Operand A comes from i_data. Operand B is the low half of the result register.
// ADD/SHL/HOLD/ACC/CLR finish in one cycle. MUL is an iterative shift-add
// that handles one multiplier bit per cycle. The result register is written
// only when the product is complete.
module iter_alu_reg #(
  parameter int W = 4
) (
  input  logic           i_clock,
  input  logic           i_reset_b,
  input  logic [W-1:0]   i_data,
  input  logic [2:0]     i_function,
  input  logic           i_go,
  output logic [2*W-1:0] o_aluout,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_ovf
);

  localparam int CW = (W < 2) ? 1 : $clog2(W + 1);

  localparam logic [2:0] F_ADD  = 3'b000;
  localparam logic [2:0] F_MUL  = 3'b001;
  localparam logic [2:0] F_SHL  = 3'b010;
  localparam logic [2:0] F_HOLD = 3'b011;
  localparam logic [2:0] F_ACC  = 3'b100;
  localparam logic [2:0] F_CLR  = 3'b101;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [2*W-1:0] r_aluout;
  logic           r_ovf;
  logic           r_done;

  // Multiplier working registers. r_mcand shifts left. r_mplier shifts right.
  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_prod;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;

  logic           w_accept;
  logic           w_start_mul;
  logic           w_mul_last;
  logic [2*W-1:0] w_partial;
  logic [2*W-1:0] w_alu_next;
  logic           w_ovf_next;
  logic [2*W-1:0] w_sum_ab;
  logic [2*W:0]   w_acc_sum;
  logic [2*W-1:0] w_shl;

  // Go is honoured only in IDLE. Requests that arrive while busy are dropped.
  assign w_accept    = i_go && (r_state == S_IDLE);
  assign w_start_mul = w_accept && (i_function == F_MUL);
  assign w_mul_last  = (r_state == S_MUL) && (r_cnt == CW'(W - 1));

  // Next partial product: add the shifted multiplicand when the current multiplier bit is set.
  assign w_partial = r_prod + (r_mplier[0] ? r_mcand : '0);

  // Operand arithmetic for the single-cycle operations.
  assign w_sum_ab  = {{W{1'b0}}, i_data} + {{W{1'b0}}, r_aluout[W-1:0]};
  assign w_acc_sum = {1'b0, r_aluout} + {{(W+1){1'b0}}, i_data};
  // If the shift amount is 2*W or more, every bit is shifted out and the result is 0.
  assign w_shl     = {{W{1'b0}}, r_aluout[W-1:0]} << i_data;

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: stay in MUL for exactly W iteration edges.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_mul) w_state_next = S_MUL;
      S_MUL:   if (w_mul_last)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: Busy is asserted whenever a multiply is running.
  always_comb begin
    o_busy   = (r_state == S_MUL);
    o_done   = r_done;
    o_ovf    = r_ovf;
    o_aluout = r_aluout;
  end

  // Result and Ovf values for each single-cycle function. Unused codes hold.
  always_comb begin
    w_alu_next = r_aluout;
    w_ovf_next = r_ovf;
    case (i_function)
      F_ADD:   w_alu_next = w_sum_ab;
      F_SHL:   w_alu_next = w_shl;
      F_ACC: begin
        w_alu_next = w_acc_sum[2*W-1:0];
        if (w_acc_sum[2*W]) w_ovf_next = 1'b1;
      end
      F_CLR: begin
        w_alu_next = '0;
        w_ovf_next = 1'b0;
      end
      default: ;  // F_HOLD and the unused codes 110/111 leave the result unchanged
    endcase
  end

  // Datapath. Single-cycle ops write at the accepting edge.
  // MUL latches its operands, iterates, and writes the product only on its last edge.
  always_ff @(posedge i_clock or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_aluout <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start_mul) begin
        r_mcand  <= {{W{1'b0}}, i_data};
        r_mplier <= r_aluout[W-1:0];
        r_prod   <= '0;
        r_cnt    <= '0;
      end else if (w_accept) begin
        r_aluout <= w_alu_next;
        r_ovf    <= w_ovf_next;
        r_done   <= 1'b1;
      end else if (r_state == S_MUL) begin
        r_prod   <= w_partial;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_mul_last) begin
          r_aluout <= w_partial;
          r_done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_alu_reg.sv
// tb_iter_alu_reg: directed tests of iter_alu_reg with W=4.
// Every expected value is computed by hand.
module tb_iter_alu_reg;
  localparam int W = 4;
  localparam logic [2:0] F_ADD  = 3'b000;
  localparam logic [2:0] F_MUL  = 3'b001;
  localparam logic [2:0] F_SHL  = 3'b010;
  localparam logic [2:0] F_HOLD = 3'b011;
  localparam logic [2:0] F_ACC  = 3'b100;
  localparam logic [2:0] F_CLR  = 3'b101;
  localparam logic [2:0] F_RSV  = 3'b110;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   data  = '0;
  logic [2:0]     func  = '0;
  logic           go    = 1'b0;
  logic [2*W-1:0] alu;
  logic           busy, done, ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iter_alu_reg #(.W(W)) dut (
    .i_clock   (clk),
    .i_reset_b (rst_n),
    .i_data    (data),
    .i_function(func),
    .i_go      (go),
    .o_aluout  (alu),
    .o_busy    (busy),
    .o_done    (done),
    .o_ovf     (ovf)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  // Present one operation for exactly one edge, then scramble Data.
  task automatic op(input logic [2:0] f, input logic [W-1:0] d);
    @(negedge clk);
    func = f; data = d; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0; data = ~d;
    $display("op f=%0d d=%0h -> alu=%02h busy=%0b done=%0b ovf=%0b", f, d, alu, busy, done, ovf);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0;
    #2;
    total++; if (alu  !== 8'h00) begin bad++; $display("FAIL reset_alu got=%02h exp=00", alu); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (ovf  !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    $display("reset released alu=%02h", alu);
  endtask

  task automatic test_acc_add();
    op(F_ACC, 4'h5);
    total++; if (alu  !== 8'h05) begin bad++; $display("FAIL acc5_alu got=%02h exp=05", alu); end
    total++; if (done !== 1'b1)  begin bad++; $display("FAIL acc5_done got=%0b exp=1", done); end
    step();
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL acc5_done_drop got=%0b exp=0", done); end
    op(F_ADD, 4'h3);
    total++; if (alu  !== 8'h08) begin bad++; $display("FAIL add3_alu got=%02h exp=08", alu); end
    total++; if (done !== 1'b1)  begin bad++; $display("FAIL add3_done got=%0b exp=1", done); end
    step();
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL add3_done_drop got=%0b exp=0", done); end
  endtask

  task automatic test_mul();
    op(F_ADD, 4'h5);  // 8 + 5 = 0x0D
    total++; if (alu !== 8'h0D) begin bad++; $display("FAIL mul_setup got=%02h exp=0D", alu); end
    op(F_MUL, 4'hF);
    for (int i = 0; i < 4; i++) begin
      total++; if ({busy, done, alu} !== {1'b1, 1'b0, 8'h0D})
        begin bad++; $display("FAIL mul_wait%0d got busy=%0b done=%0b alu=%02h exp 1 0 0D", i, busy, done, alu); end
      if (i < 3) step();
      else begin
        step();
        total++; if ({busy, done, alu} !== {1'b0, 1'b1, 8'hC3})
          begin bad++; $display("FAIL mul_result got busy=%0b done=%0b alu=%02h exp 0 1 C3", busy, done, alu); end
      end
    end
    $display("mul 0D*F -> alu=%02h", alu);
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_drop got=%0b exp=0", done); end
  endtask

  task automatic test_shl();
    op(F_CLR, 4'h0);
    op(F_ADD, 4'h3);
    op(F_SHL, 4'h6);
    total++; if (alu !== 8'hC0) begin bad++; $display("FAIL shl6 got=%02h exp=C0", alu); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL shl6_done got=%0b exp=1", done); end
    op(F_CLR, 4'h0);
    op(F_ADD, 4'h3);
    op(F_SHL, 4'h8);
    total++; if (alu !== 8'h00) begin bad++; $display("FAIL shl8 got=%02h exp=00", alu); end
  endtask

  task automatic test_ovf();
    op(F_CLR, 4'h0);
    op(F_ADD, 4'hF);  // 0x0F
    op(F_SHL, 4'h4);  // 0xF0
    op(F_ACC, 4'hE);  // 0xFE
    total++; if ({alu, ovf} !== {8'hFE, 1'b0}) begin bad++; $display("FAIL ovf_setup got alu=%02h ovf=%0b exp FE 0", alu, ovf); end
    op(F_ACC, 4'h5);  // 0x103 wraps to 0x03
    total++; if ({alu, ovf} !== {8'h03, 1'b1}) begin bad++; $display("FAIL acc_wrap got alu=%02h ovf=%0b exp 03 1", alu, ovf); end
    op(F_ADD, 4'h1);  // 3 + 1
    total++; if ({alu, ovf} !== {8'h04, 1'b1}) begin bad++; $display("FAIL ovf_add got alu=%02h ovf=%0b exp 04 1", alu, ovf); end
    op(F_HOLD, 4'h9);
    total++; if ({alu, ovf, done} !== {8'h04, 1'b1, 1'b1}) begin bad++; $display("FAIL hold got alu=%02h ovf=%0b done=%0b exp 04 1 1", alu, ovf, done); end
    op(F_RSV, 4'h9);
    total++; if ({alu, ovf, done} !== {8'h04, 1'b1, 1'b1}) begin bad++; $display("FAIL rsv110 got alu=%02h ovf=%0b done=%0b exp 04 1 1", alu, ovf, done); end
    op(F_CLR, 4'h7);
    total++; if ({alu, ovf} !== {8'h00, 1'b0}) begin bad++; $display("FAIL clr got alu=%02h ovf=%0b exp 00 0", alu, ovf); end
  endtask

  task automatic test_busy_ignore();
    int dones;
    op(F_ADD, 4'h3);  // 0x03
    op(F_MUL, 4'h5);  // 3*5 = 0x0F
    dones = 0;
    @(negedge clk); func = F_ADD; data = 4'h1; go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    if (done) dones++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dones++;
    end
    total++; if (alu !== 8'h0F) begin bad++; $display("FAIL ignore_alu got=%02h exp=0F", alu); end
    total++; if (dones != 1) begin bad++; $display("FAIL ignore_dones got=%0d exp=1", dones); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_busy got=%0b exp=0", busy); end
    $display("busy-ignore mul 3*5 -> alu=%02h dones=%0d", alu, dones);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); func = F_ACC; data = 4'h1; go = 1'b1;
    step();
    total++; if ({alu, done} !== {8'h10, 1'b1}) begin bad++; $display("FAIL b2b_acc1 got alu=%02h done=%0b exp 10 1", alu, done); end
    step();
    total++; if ({alu, done} !== {8'h11, 1'b1}) begin bad++; $display("FAIL b2b_acc2 got alu=%02h done=%0b exp 11 1", alu, done); end
    step();
    total++; if ({alu, done} !== {8'h12, 1'b1}) begin bad++; $display("FAIL b2b_acc3 got alu=%02h done=%0b exp 12 1", alu, done); end
    @(negedge clk); func = F_MUL; data = 4'h2;
    step();
    total++; if ({busy, done} !== {1'b1, 1'b0}) begin bad++; $display("FAIL b2b_mul_start got busy=%0b done=%0b exp 1 0", busy, done); end
    for (int i = 0; i < 4; i++) step();
    total++; if ({alu, busy, done} !== {8'h04, 1'b0, 1'b1}) begin bad++; $display("FAIL b2b_mul1 got alu=%02h busy=%0b done=%0b exp 04 0 1", alu, busy, done); end
    step();  // Go still high: a second MUL starts right away
    total++; if ({alu, busy, done} !== {8'h04, 1'b1, 1'b0}) begin bad++; $display("FAIL b2b_restart got alu=%02h busy=%0b done=%0b exp 04 1 0", alu, busy, done); end
    go = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++; if ({alu, busy, done} !== {8'h08, 1'b0, 1'b1}) begin bad++; $display("FAIL b2b_mul2 got alu=%02h busy=%0b done=%0b exp 08 0 1", alu, busy, done); end
    $display("back-to-back -> alu=%02h", alu);
    step();
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    op(F_MUL, 4'h3);  // 8*3 would be 0x18
    step(); step();
    #3;
    rst_n = 1'b0;
    #1;
    total++; if ({alu, busy, done, ovf} !== {8'h00, 1'b0, 1'b0, 1'b0})
      begin bad++; $display("FAIL async_reset got alu=%02h busy=%0b done=%0b ovf=%0b exp all 0", alu, busy, done, ovf); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%0b exp=0", seen); end
    total++; if (alu !== 8'h00) begin bad++; $display("FAIL abort_alu got=%02h exp=00", alu); end
    op(F_ADD, 4'h7);
    total++; if ({alu, done} !== {8'h07, 1'b1}) begin bad++; $display("FAIL post_reset_add got alu=%02h done=%0b exp 07 1", alu, done); end
  endtask

  initial begin
    test_reset();
    test_acc_add();
    test_mul();
    test_shl();
    test_ovf();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_alu_reg.md
ITER_ALU_REG -- requirements
Module: iter_alu_reg

Interface
REQ-001 Parameter W, default 4: operand width; result register width is 2*W; W SHALL be >= 2.
REQ-002 Clock  input  1  single clock, all state updates on rising edge.
REQ-003 Reset_b  input  1  reset, asynchronous, active-low.
REQ-004 Data  input  W  operand A.
REQ-005 Function  input  3  operation select, sampled with Go.
REQ-006 Go  input  1  start request; accepted only when Busy=0.
REQ-007 ALUout  output  2*W  registered result; operand B is ALUout[W-1:0].
REQ-008 Busy  output  1  high while a multi-cycle multiply is in progress.
REQ-009 Done  output  1  one-cycle pulse marking an ALUout update from an accepted operation.
REQ-010 Ovf  output  1  sticky flag, set when an add or accumulate result exceeds 2*W bits.

Function
REQ-011 Operand capture: on the accepting edge, A=Data and B=ALUout[W-1:0] SHALL be latched; later Data changes SHALL NOT affect the operation.
REQ-012 Function 000 ADD: ALUout <= zero-extended A+B; single-cycle.
REQ-013 Function 001 MUL: ALUout <= A*B (unsigned, full 2*W product); multi-cycle shift-add, one multiplier bit per cycle.
REQ-014 Function 010 SHL: ALUout <= zero-extended B shifted left by A; shift amount >= 2*W yields 0; single-cycle.
REQ-015 Function 011 HOLD: ALUout unchanged; Done still pulses; single-cycle.
REQ-016 Function 100 ACC: ALUout <= ALUout + A, modulo 2^(2*W); carry out of bit 2*W-1 sets Ovf; single-cycle.
REQ-017 Function 101 CLR: ALUout <= 0 and Ovf <= 0; single-cycle.
REQ-018 Functions 110, 111: treated as HOLD.
REQ-019 ADD never overflows 2*W bits (W>=2); Ovf SHALL only change on ACC or CLR.
REQ-020 States: IDLE, MUL. IDLE->MUL on accepted Go with Function 001; MUL->IDLE after exactly W iteration edges; all other accepted ops stay in IDLE.
REQ-021 Single-cycle latency: Go=1 sampled at edge k with Busy=0 -> ALUout updated at edge k, Done=1 for the cycle after edge k only.
REQ-022 MUL latency: accepted at edge k -> Busy=1 after edge k; iterations at edges k+1..k+W; ALUout updated, Busy=0 and Done=1 after edge k+W; Done high one cycle.
REQ-023 ALUout SHALL hold its previous value throughout a MUL until edge k+W (no partial products visible).
REQ-024 Go while Busy=1 SHALL be ignored entirely (no queueing, no state change).
REQ-025 Go held high continuously in IDLE SHALL start a new operation on every edge where Busy=0, including the edge after a MUL completes.
REQ-026 Done SHALL be 0 on any cycle not following a completion edge.

Reset
REQ-027 Reset_b=0 SHALL immediately, without a clock edge, force ALUout=0, Busy=0, Done=0, Ovf=0, state IDLE, internal multiplier registers 0.
REQ-028 Reset mid-MUL SHALL abort the multiply; no Done pulse SHALL follow.
REQ-029 First operation SHALL be accepted on the first rising edge with Reset_b=1 and Go=1.

Verification (W=4)
REQ-030 Reset, ACC Data=5, then ADD Data=3 -> ALUout=5 then 8; Done pulses once per op, one cycle after each accepting edge.
REQ-031 ALUout=0x0D, MUL Data=0xF -> Busy high 4 cycles, ALUout stays 0x0D until the 4th edge, then 0xC3 with Done=1 for one cycle.
REQ-032 ALUout=0x03, SHL Data=6 -> 0xC0; ALUout=0x03, SHL Data=8 -> 0x00.
REQ-033 ALUout=0xFE, ACC Data=5 -> ALUout=0x03, Ovf=1; then ADD, HOLD keep Ovf=1; CLR -> ALUout=0, Ovf=0.
REQ-034 Go pulsed with ADD during an active MUL -> ignored; only the MUL result and one Done appear.
REQ-035 Reset_b low between clock edges mid-MUL -> outputs 0 immediately, Busy=0, no Done after release.
